// File: rtl/syn_tle_acc_pkg.sv
// Shared types and helpers for the syn_tle_acc tile accumulator.
// Provides the saturating adder used when SYN_TLE_ACC_SAT_EN is defined.
package syn_tle_acc_pkg;

  localparam int DEF_P = 8;
  localparam int ACC_W = 4 * DEF_P;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Signed add clamped to a w-bit range; operands arrive sign-extended, w <= 62.
  function automatic longint sat_add(input longint a, input longint b, input int w,
                                     output logic clamp);
    longint s, hi, lo;
    hi    = (longint'(1) <<< (w - 1)) - 1;
    lo    = -hi - 1;
    s     = a + b;
    clamp = 1'b0;
    if (s > hi) begin
      s     = hi;
      clamp = 1'b1;
    end else if (s < lo) begin
      s     = lo;
      clamp = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/syn_tle_dot.sv
// One K-length signed dot product for a single (m,n) output element.
// In half mode each P-bit element carries two signed P/2-bit lanes.
module syn_tle_dot
  import syn_tle_acc_pkg::*;
#(
  parameter int K = 16,
  parameter int P = DEF_P,
  localparam int AW = 4 * P
) (
  input  logic [K-1:0][P-1:0] a,
  input  logic [K-1:0][P-1:0] b,
  input  logic                half,
  output logic [AW-1:0]       term
);

  logic signed [AW-1:0] s;

  // Products are formed at AW bits, so the sum is the full-precision sum mod 2^AW.
  always_comb begin
    s = '0;
    for (int k = 0; k < K; k++) begin
      if (half)
        s = s + AW'($signed(a[k][P-1:P/2])) * AW'($signed(b[k][P-1:P/2]))
              + AW'($signed(a[k][P/2-1:0])) * AW'($signed(b[k][P/2-1:0]));
      else
        s = s + AW'($signed(a[k])) * AW'($signed(b[k]));
    end
    term = s;
  end

endmodule

// File: rtl/syn_tle_acc.sv
// Multi-beat K-accumulating tensor tile engine: D = C + sum(A*B) over a packet.
// Define SYN_TLE_ACC_SAT_EN for per-element saturating accumulation and sat_o.
module syn_tle_acc
  import syn_tle_acc_pkg::*;
#(
  parameter int M         = 8,
  parameter int N         = 4,
  parameter int K         = 16,
  parameter int P         = DEF_P,
  parameter int MAX_BEATS = 16,
  localparam int CW = $clog2(MAX_BEATS + 1),
  localparam int AW = 4 * P
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic signed [M-1:0][K-1:0][P-1:0]  A_i,
  input  logic signed [K-1:0][N-1:0][P-1:0]  B_i,
  input  logic signed [M-1:0][N-1:0][AW-1:0] C_i,
  input  logic                               half_i,
  input  logic                               last_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic signed [M-1:0][N-1:0][AW-1:0] D_o,
  output logic [CW-1:0]                      beats_o,
  output logic                               err_o,
  output logic                               valid_o,
  input  logic                               ready_i
`ifdef SYN_TLE_ACC_SAT_EN
  ,
  output logic [M-1:0][N-1:0]                sat_o
`endif
);

  state_e                       state;
  logic                         mode_q, err;
  logic [CW-1:0]                cnt, cnt_nxt;
  logic [M-1:0][N-1:0][AW-1:0]  acc, acc_nxt, term;
  logic                         first, mode, fin;

  assign first   = (state == IDLE);
  assign mode    = first ? half_i : mode_q;
  assign cnt_nxt = first ? CW'(1) : cnt + CW'(1);
  assign fin     = last_i || (cnt_nxt == CW'(MAX_BEATS));

`ifdef SYN_TLE_ACC_SAT_EN
  logic [M-1:0][N-1:0] clamp, sat_q;
  assign sat_o = sat_q;
`endif

  for (genvar gm = 0; gm < M; gm++) begin : g_m
    for (genvar gn = 0; gn < N; gn++) begin : g_n
      logic [K-1:0][P-1:0] bcol;
      logic [AW-1:0]       base;

      always_comb
        for (int k = 0; k < K; k++) bcol[k] = B_i[k][gn];

      syn_tle_dot #(.K(K), .P(P)) u_dot (
        .a   (A_i[gm]),
        .b   (bcol),
        .half(mode),
        .term(term[gm][gn])
      );

      // C seeds the accumulator only on the opening beat of a packet.
      assign base = first ? C_i[gm][gn] : acc[gm][gn];

`ifdef SYN_TLE_ACC_SAT_EN
      longint sum;
      logic   c;
      always_comb begin
        c   = 1'b0;
        sum = sat_add(longint'($signed(base)), longint'($signed(term[gm][gn])), AW, c);
      end
      assign acc_nxt[gm][gn] = AW'(sum);
      assign clamp[gm][gn]   = c;
`else
      assign acc_nxt[gm][gn] = base + term[gm][gn];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
`ifdef SYN_TLE_ACC_SAT_EN
      sat_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: if (valid_i) begin
          if (first) mode_q <= half_i;
          acc   <= acc_nxt;
          cnt   <= cnt_nxt;
          state <= fin ? OUT : ACCUM;
          if (cnt_nxt == CW'(MAX_BEATS) && !last_i) err <= 1'b1;
`ifdef SYN_TLE_ACC_SAT_EN
          sat_q <= first ? clamp : (sat_q | clamp);
`endif
        end
        OUT: if (ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o = (state != OUT);
  assign valid_o = (state == OUT);
  assign D_o     = acc;
  assign beats_o = cnt;
  assign err_o   = err;

endmodule

// File: tb/tb_syn_tle_acc.sv
// Self-checking bench for syn_tle_acc: directed cases plus random packets
// compared against an element-wise arithmetic reference model.
module tb_syn_tle_acc;

  localparam int M = 2, N = 2, K = 2, P = 8, MB = 3;
  localparam int CW = $clog2(MB + 1);
  localparam int AW = 4 * P;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [M-1:0][K-1:0][P-1:0]  A_i = '0;
  logic [K-1:0][N-1:0][P-1:0]  B_i = '0;
  logic [M-1:0][N-1:0][AW-1:0] C_i = '0;
  logic half_i = 1'b0, last_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic ready_o, err_o, valid_o;
  logic [M-1:0][N-1:0][AW-1:0] D_o;
  logic [CW-1:0] beats_o;
`ifdef SYN_TLE_ACC_SAT_EN
  logic [M-1:0][N-1:0] sat_o;
`endif

  always #5 clk = ~clk;

  syn_tle_acc #(.M(M), .N(N), .K(K), .P(P), .MAX_BEATS(MB)) dut (
    .clk_i(clk), .rst_i(rst_i), .A_i(A_i), .B_i(B_i), .C_i(C_i),
    .half_i(half_i), .last_i(last_i), .valid_i(valid_i), .ready_o(ready_o),
    .D_o(D_o), .beats_o(beats_o), .err_o(err_o), .valid_o(valid_o),
    .ready_i(ready_i)
`ifdef SYN_TLE_ACC_SAT_EN
    , .sat_o(sat_o)
`endif
  );

  int checks = 0, failures = 0;

  // stimulus for the next beat
  int     ra[M][K], rb[K][N];
  longint rc[M][N];
  bit     rhalf;

  // reference model state
  longint macc[M][N];
  bit     msat[M][N];
  int     mcnt = 0;
  bit     mmode = 0, in_pkt = 0, merr = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint r;
    r = v & longint'(64'hFFFF_FFFF);
    if (r > longint'(64'h7FFF_FFFF)) r = r - longint'(64'h1_0000_0000);
    return r;
  endfunction

  function automatic int sx8(input int x);
    int v;
    v = x & 255;
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int lane(input int x, input bit hi);
    int v;
    v = hi ? ((x & 255) >> 4) : (x & 15);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic longint addm(input longint a, input longint b, output bit c);
    longint s;
    s = a + b;
    c = 0;
`ifdef SYN_TLE_ACC_SAT_EN
    if (s > 64'sd2147483647) begin s = 64'sd2147483647; c = 1; end
    else if (s < -64'sd2147483648) begin s = -64'sd2147483648; c = 1; end
`else
    s = wrap(s);
`endif
    return s;
  endfunction

  task automatic model_beat(input bit last, output bit fin);
    longint t;
    bit c;
    if (!in_pkt) begin
      mmode = rhalf;
      mcnt  = 0;
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++) begin
          macc[m][n] = rc[m][n];
          msat[m][n] = 0;
        end
    end
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) begin
        t = 0;
        for (int k = 0; k < K; k++)
          if (mmode)
            t += lane(ra[m][k], 1) * lane(rb[k][n], 1) + lane(ra[m][k], 0) * lane(rb[k][n], 0);
          else
            t += sx8(ra[m][k]) * sx8(rb[k][n]);
        macc[m][n] = addm(macc[m][n], wrap(t), c);
        msat[m][n] = msat[m][n] | c;
      end
    mcnt++;
    fin = last || (mcnt == MB);
    if (mcnt == MB && !last) merr = 1;
    in_pkt = !fin;
  endtask

  task automatic beat(input bit last, output bit fin);
    int w = 0;
    while (!ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", longint'(ready_o), 1);
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) A_i[m][k] = ra[m][k][P-1:0];
    for (int k = 0; k < K; k++)
      for (int n = 0; n < N; n++) B_i[k][n] = rb[k][n][P-1:0];
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) C_i[m][n] = rc[m][n][AW-1:0];
    half_i  = rhalf;
    last_i  = last;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    model_beat(last, fin);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag);
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) begin
        chk($sformatf("%s_d%0d%0d", tag, m, n), longint'($signed(D_o[m][n])), macc[m][n]);
`ifdef SYN_TLE_ACC_SAT_EN
        chk($sformatf("%s_sat%0d%0d", tag, m, n), longint'(sat_o[m][n]), longint'(msat[m][n]));
`endif
      end
    chk({tag, "_beats"}, longint'(beats_o), mcnt);
    chk({tag, "_err"}, longint'(err_o), longint'(merr));
    chk({tag, "_vo"}, longint'(valid_o), 1);
    chk({tag, "_ro"}, longint'(ready_o), 0);
  endtask

  task automatic drain(input string tag, input int stall);
    check_out(tag);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_out({tag, "_hold"});
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk({tag, "_vo_done"}, longint'(valid_o), 0);
    chk({tag, "_ro_done"}, longint'(ready_o), 1);
  endtask

  task automatic randomize_beat();
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) ra[m][k] = int'($urandom_range(255)) - 128;
    for (int k = 0; k < K; k++)
      for (int n = 0; n < N; n++) rb[k][n] = int'($urandom_range(255)) - 128;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        rc[m][n] = ($urandom_range(3) == 0) ? wrap(longint'($urandom))
                                             : longint'(int'($urandom_range(2000)) - 1000);
    rhalf = 1'($urandom_range(1));
  endtask

  // nb beats with last on the final one; rnd re-randomises data per beat
  task automatic send_pkt(input string tag, input int nb, input int stall,
                          input bit rnd, input bit tog);
    bit fin = 0;
    for (int b = 0; b < nb; b++) begin
      if (rnd) randomize_beat();
      beat(b == nb - 1, fin);
      if (tog) rhalf = !rhalf;
      if (fin) break;
      chk({tag, "_vo_mid"}, longint'(valid_o), 0);
      chk({tag, "_ro_mid"}, longint'(ready_o), 1);
    end
    drain(tag, stall);
  endtask

  task automatic clear_stim();
    for (int m = 0; m < M; m++) for (int k = 0; k < K; k++) ra[m][k] = 0;
    for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) rb[k][n] = 0;
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) rc[m][n] = 0;
    rhalf = 0;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_vo"}, longint'(valid_o), 0);
    chk({tag, "_ro"}, longint'(ready_o), 1);
    chk({tag, "_err"}, longint'(err_o), 0);
    chk({tag, "_beats"}, longint'(beats_o), 0);
    chk({tag, "_d"}, longint'(D_o == '0), 1);
  endtask

  initial begin
    bit fin;
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    reset_check("rst0");

    // 2x2 matrix product, single beat
    clear_stim();
    ra[0][0] = 1; ra[0][1] = 2; ra[1][0] = 3; ra[1][1] = 4;
    rb[0][0] = 5; rb[0][1] = 6; rb[1][0] = 7; rb[1][1] = 8;
    beat(1'b1, fin);
    chk("t1_d00", longint'($signed(D_o[0][0])), 19);
    chk("t1_d01", longint'($signed(D_o[0][1])), 22);
    chk("t1_d10", longint'($signed(D_o[1][0])), 43);
    chk("t1_d11", longint'($signed(D_o[1][1])), 50);
    drain("t1", 0);

    // three beats with C=10 seeded on the first beat only
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) rc[m][n] = 10;
    send_pkt("t2", 3, 1, 0, 0);
    chk("t2_d11_const", macc[1][1], 160);

    // half mode, half_i flipped on beat 2 must not matter
    clear_stim();
    ra[0][0] = 'h21; rb[0][0] = 'h43; rhalf = 1;
    beat(1'b0, fin);
    rhalf = 0;
    beat(1'b1, fin);
    chk("half_d00", longint'($signed(D_o[0][0])), 22);
    drain("half", 0);

    // beat limit: three non-last beats end the packet and set err
    send_pkt("lim", 4, 0, 1, 0);
    send_pkt("after_lim", 1, 5, 1, 0);

    // reset in the middle of accumulation discards the partial sum
    randomize_beat();
    beat(1'b0, fin);
    beat(1'b0, fin);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    in_pkt = 0;
    merr   = 0;
    @(negedge clk);
    reset_check("rst_mid");
    send_pkt("post_rst", 1, 0, 1, 0);

    // accumulator overflow boundary
    clear_stim();
    ra[0][0] = 10; rb[0][0] = 10; rc[0][0] = 64'sh7FFF_FFF0;
    beat(1'b1, fin);
`ifdef SYN_TLE_ACC_SAT_EN
    chk("sat_d00", longint'($signed(D_o[0][0])), 64'sd2147483647);
    chk("sat_flag", longint'(sat_o[0][0]), 1);
`else
    chk("wrap_d00", longint'($signed(D_o[0][0])), -64'sd2147483564);
`endif
    drain("ovf", 0);

    for (int i = 0; i < 40; i++)
      send_pkt($sformatf("rnd%0d", i), int'($urandom_range(1, 4)),
               int'($urandom_range(3)), 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
